// File: rtl/i4001_rom_arb_pkg.sv
// Shared types and defaults for the i4001 ROM arbiter.
// Tag ids are sized for the largest supported port count (16).
package i4001_rom_arb_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;
    localparam int MAX_TAG_W  = 4;

    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [MAX_TAG_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/i4001_rr_arbiter.sv
// Round-robin picker: first eligible index at or above ptr, wrapping.
// Purely combinational; returns one-hot grant and its index.
module i4001_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          gnt_valid,
    output logic [PW-1:0] gnt_idx
);

    always_comb begin
        int idx;
        grant     = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!gnt_valid && eligible[idx]) begin
                gnt_valid  = 1'b1;
                gnt_idx    = PW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i4001_rom_arbiter.sv
// Shares one block-RAM ROM among NUM_PORTS i4001 fetch buses.
// Define I4001_ROM_ARB_FIXED_PRI_EN to give port 0 absolute priority.
module i4001_rom_arbiter
    import i4001_rom_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RAM_LATENCY = 1
) (
    input  logic                        sysclk,
    input  logic                        poc,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    output logic [NUM_PORTS-1:0]        ack,
    output logic [NUM_PORTS*DATA_W-1:0] port_data,
    output logic                        bram_en,
    output logic [ADDR_W-1:0]           bram_addr,
    input  logic [DATA_W-1:0]           bram_data
);

    localparam int PW    = tag_w(NUM_PORTS);
    localparam int DEPTH = RAM_LATENCY + 1;

    logic [NUM_PORTS-1:0] inflight, eligible, rr_elig;
    logic [NUM_PORTS-1:0] rr_grant, gnt_vec, done_vec;
    logic [PW-1:0]        ptr, rr_idx, gnt_idx;
    logic                 rr_valid, gnt_valid, adv_ptr;
    logic [ADDR_W-1:0]    gnt_addr;
    tag_t                 pipe [DEPTH];

    assign eligible = req & ~inflight & ~ack;

    i4001_rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_rr (
        .eligible  (rr_elig),
        .ptr       (ptr),
        .grant     (rr_grant),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

`ifdef I4001_ROM_ARB_FIXED_PRI_EN
    // Port 0 bypasses the rotation and never moves the pointer.
    assign rr_elig = eligible & ~NUM_PORTS'(1);
    always_comb begin
        gnt_valid = rr_valid;
        gnt_idx   = rr_idx;
        gnt_vec   = rr_grant;
        adv_ptr   = rr_valid;
        if (eligible[0]) begin
            gnt_valid = 1'b1;
            gnt_idx   = '0;
            gnt_vec   = NUM_PORTS'(1);
            adv_ptr   = 1'b0;
        end
    end
`else
    assign rr_elig   = eligible;
    assign gnt_valid = rr_valid;
    assign gnt_idx   = rr_idx;
    assign gnt_vec   = rr_grant;
    assign adv_ptr   = rr_valid;
`endif

    always_comb begin
        gnt_addr = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gnt_vec[i]) gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        done_vec = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            done_vec[i] = pipe[DEPTH-1].valid &&
                          (pipe[DEPTH-1].id == MAX_TAG_W'(i));
        end
    end

    always_ff @(posedge sysclk or posedge poc) begin
        if (poc) begin
            ack       <= '0;
            port_data <= '0;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            ptr       <= '0;
            inflight  <= '0;
            for (int s = 0; s < DEPTH; s++) pipe[s] <= '0;
        end else begin
            ack      <= done_vec;
            inflight <= (inflight & ~done_vec) | gnt_vec;
            bram_en  <= gnt_valid;
            if (gnt_valid) bram_addr <= gnt_addr;
            if (adv_ptr) begin
                if (int'(gnt_idx) == NUM_PORTS - 1) ptr <= '0;
                else ptr <= gnt_idx + 1'b1;
            end
            pipe[0].valid <= gnt_valid;
            pipe[0].id    <= gnt_valid ? MAX_TAG_W'(gnt_idx) : '0;
            for (int s = 1; s < DEPTH; s++) pipe[s] <= pipe[s-1];
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (done_vec[i]) port_data[i*DATA_W +: DATA_W] <= bram_data;
            end
        end
    end

endmodule

// File: tb/tb_i4001_rom_arbiter.sv
// Directed bench for i4001_rom_arbiter (4 ports, RAM_LATENCY=1).
// Honours I4001_ROM_ARB_FIXED_PRI_EN for the priority vector.
module tb_i4001_rom_arbiter;

    logic        sysclk = 1'b0;
    logic        poc = 1'b1;
    logic [3:0]  req = '0;
    logic [47:0] req_addr;
    logic [3:0]  ack;
    logic [31:0] port_data;
    logic        bram_en;
    logic [11:0] bram_addr;
    logic [7:0]  bram_data = '0;

    logic [7:0]  rom [4096];
    int          total = 0;
    int          bad = 0;
    int          c1, c3;

    i4001_rom_arbiter dut (
        .sysclk    (sysclk),
        .poc       (poc),
        .req       (req),
        .req_addr  (req_addr),
        .ack       (ack),
        .port_data (port_data),
        .bram_en   (bram_en),
        .bram_addr (bram_addr),
        .bram_data (bram_data)
    );

    always #5 sysclk = ~sysclk;

    // One-cycle block-RAM model
    always @(posedge sysclk) bram_data <= rom[bram_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    task automatic do_reset;
        poc = 1'b1;
        req = '0;
        tick();
        poc = 1'b0;
    endtask

    function automatic logic [7:0] pd(input int i);
        return port_data[i*8 +: 8];
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'(i) ^ 8'hA5;
        rom[12'h2A5] = 8'h3C;
        req_addr = {12'h3C7, 12'h2A5, 12'h1F3, 12'h100};

        @(negedge sysclk);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_data", port_data, 0);
        chk("rst_en", 32'(bram_en), 0);
        chk("rst_addr", 32'(bram_addr), 0);
        poc = 1'b0;

        // Single request on port 2
        req = 4'b0100;
        tick();
        chk("s_addr", 32'(bram_addr), 32'h2A5);
        chk("s_en0", 32'(bram_en), 1);
        chk("s_ack0", 32'(ack), 0);
        tick();
        chk("s_en1", 32'(bram_en), 0);
        chk("s_ack1", 32'(ack), 0);
        tick();
        chk("s_ack2", 32'(ack), 32'b0100);
        chk("s_data", 32'(pd(2)), 32'h3C);
        req = req & ~ack;
        tick();
        chk("s_ack3", 32'(ack), 0);
        chk("s_hold", 32'(pd(2)), 32'h3C);

        // All four ports from pointer 0
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("a_en%0d", i), 32'(bram_en), (i < 4) ? 1 : 0);
            if (i < 4)
                chk($sformatf("a_addr%0d", i), 32'(bram_addr),
                    32'(req_addr[i*12 +: 12]));
            chk($sformatf("a_ack%0d", i), 32'(ack),
                (i >= 2) ? (32'd1 << (i - 2)) : 0);
            req = req & ~ack;
        end
        for (int p = 0; p < 4; p++)
            chk($sformatf("a_data%0d", p), 32'(pd(p)),
                32'(rom[req_addr[p*12 +: 12]]));

        // Port 0 holds req through its ack
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("h_en%0d", i), 32'(bram_en),
                (i == 0 || i == 4) ? 1 : 0);
            chk($sformatf("h_ack%0d", i), 32'(ack), (i == 2) ? 1 : 0);
        end
        req = '0;
        tick();
        tick();
        chk("h_ack6", 32'(ack), 1);
        tick();

        // Reset while port 1 is in flight
        do_reset();
        req = 4'b0010;
        tick();
        chk("r_en", 32'(bram_en), 1);
        poc = 1'b1;
        #1;
        chk("r_ack", 32'(ack), 0);
        chk("r_en0", 32'(bram_en), 0);
        chk("r_addr0", 32'(bram_addr), 0);
        chk("r_data0", port_data, 0);
        tick();
        chk("r_ack_h", 32'(ack), 0);
        poc = 1'b0;
        tick();
        chk("r_regrant", 32'(bram_en), 1);
        chk("r_addr1", 32'(bram_addr), 32'h1F3);
        tick();
        chk("r_ack1", 32'(ack), 0);
        tick();
        chk("r_ack2", 32'(ack), 32'b0010);
        chk("r_data1", 32'(pd(1)), 32'(rom[12'h1F3]));
        req = req & ~ack;
        tick();

        // Fairness between ports 1 and 3
        do_reset();
        c1 = 0;
        c3 = 0;
        req = 4'b1010;
        for (int i = 0; i < 100; i++) begin
            tick();
            c1 += int'(ack[1]);
            c3 += int'(ack[3]);
            req[1] = ~ack[1];
            req[3] = ~ack[3];
        end
        chk("f_diff", 32'((c1 - c3 <= 1) && (c3 - c1 <= 1)), 1);
        chk("f_p1", 32'(c1 >= 20), 1);
        chk("f_p3", 32'(c3 >= 20), 1);
        req = '0;
        tick();
        tick();
        tick();

        // Ports 0 and 2 together with pointer parked at 2
        do_reset();
        req = 4'b0010;
        tick();
        tick();
        tick();
        req = req & ~ack;
        tick();
        req = 4'b0101;
        tick();
`ifdef I4001_ROM_ARB_FIXED_PRI_EN
        chk("p_first", 32'(bram_addr), 32'h100);
        tick();
        chk("p_second", 32'(bram_addr), 32'h2A5);
`else
        chk("p_first", 32'(bram_addr), 32'h2A5);
        tick();
        chk("p_second", 32'(bram_addr), 32'h100);
`endif
        chk("p_en", 32'(bram_en), 1);
        req = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
